icache_refill: RTL and testbench

Refill and flush writer for the two-way instruction cache arrays. It accepts a miss request (index, tag, victim way), fetches the line from the next level as two half-line beats, and writes the data and tag arrays through their write ports. It also provides a whole-cache invalidate walk. It sits between the icache miss logic and the icache tag/data memories. Its outputs connect directly to the memories' write enables, addresses and write data.

---
 rtl/icache_refill.sv | 195 +++++++++++++++++++
 tb/tb_icache_refill.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// icache_refill
//   Refill and flush writer for the two-way instruction cache arrays.
//   It takes a miss (index, tag, victim way) and first invalidates the victim
//   tag. It then fetches the line as two half-line beats and writes each beat
//   straight into the data RAM. Last, it writes the victim tag, which is valid
//   only when the fill was clean. It also runs a whole-cache invalidate walk.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_*                      miss request (valid/ready, index, tag, way)
//   flush_req / flush_done     level flush request / walk-complete pulse
//   mem_req_*                  line fetch request to the next level
//   mem_rsp_*                  beat stream from the next level
//   tagram_en, tag_array*_wr_en, tag_addr, tag_din       tag RAM write port
//   dataram_en, *_data_array_wr_en, data_addr, data_din  data RAM write port
//   done_*                     refill completion pulse and its attributes
module icache_refill #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 20,
  parameter int LINE_W  = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // miss request
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [INDEX_W-1:0]       req_index,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic                     req_way,
  // flush
  input  logic                     flush_req,
  output logic                     flush_done,
  // next-level fetch
  output logic                     mem_req_vld,
  input  logic                     mem_req_rdy,
  output logic [TAG_W+INDEX_W-1:0] mem_req_addr,
  input  logic                     mem_rsp_vld,
  output logic                     mem_rsp_rdy,
  input  logic [LINE_W/2-1:0]      mem_rsp_data,
  input  logic                     mem_rsp_last,
  input  logic                     mem_rsp_err,
  // tag RAM write port
  output logic                     tagram_en,
  output logic                     tag_arrayA_wr_en,
  output logic                     tag_arrayB_wr_en,
  output logic [INDEX_W-1:0]       tag_addr,
  output logic [TAG_W:0]           tag_din,
  // data RAM write port
  output logic                     dataram_en,
  output logic                     A_data_array_wr_en,
  output logic                     B_data_array_wr_en,
  output logic [INDEX_W:0]         data_addr,
  output logic [LINE_W/2-1:0]      data_din,
  // completion
  output logic                     done_vld,
  output logic                     done_err,
  output logic [INDEX_W-1:0]       done_index,
  output logic                     done_way
);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_INV, S_MREQ, S_FILL, S_TAGWR
  } state_t;

  state_t               r_state;
  logic [INDEX_W-1:0]   r_cnt;     // flush walk address
  logic [INDEX_W-1:0]   r_index;
  logic [TAG_W-1:0]     r_tag;
  logic                 r_way;
  logic [1:0]           r_beat;    // saturates at 2
  logic                 r_err;

  logic                 w_beat_err;
  logic                 w_beat_hs;
  logic                 w_beat_wr;

  // A beat is bad if it is flagged, if beat 0 claims to be last, or if any
  // later beat is not last (the line is exactly two beats).
  assign w_beat_err = mem_rsp_err
                    | (mem_rsp_last  && (r_beat == 2'd0))
                    | (!mem_rsp_last && (r_beat != 2'd0));
  assign w_beat_hs  = (r_state == S_FILL) && mem_rsp_vld;
  // Beats past the second are accepted but never reach the data RAM.
  assign w_beat_wr  = w_beat_hs && (r_beat != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_index <= '0;
      r_tag   <= '0;
      r_way   <= 1'b0;
      r_beat  <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_req) begin
            r_cnt   <= '0;
            r_state <= S_FLUSH;
          end else if (req_vld) begin
            r_index <= req_index;
            r_tag   <= req_tag;
            r_way   <= req_way;
            r_beat  <= 2'd0;
            r_err   <= 1'b0;
            r_state <= S_INV;
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt + 1'b1;   // wraps back to 0 on the final set
          if (&r_cnt) r_state <= S_IDLE;
        end
        S_INV:   r_state <= S_MREQ;
        S_MREQ:  if (mem_req_rdy) r_state <= S_FILL;
        S_FILL: begin
          if (mem_rsp_vld) begin
            if (r_beat != 2'd2) r_beat <= r_beat + 2'd1;
            r_err <= r_err | w_beat_err;
            if (mem_rsp_last) r_state <= S_TAGWR;
          end
        end
        S_TAGWR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_rdy            = 1'b0;
    flush_done         = 1'b0;
    mem_req_vld        = 1'b0;
    mem_req_addr       = '0;
    mem_rsp_rdy        = 1'b0;
    tagram_en          = 1'b0;
    tag_arrayA_wr_en   = 1'b0;
    tag_arrayB_wr_en   = 1'b0;
    tag_addr           = '0;
    tag_din            = '0;
    dataram_en         = 1'b0;
    A_data_array_wr_en = 1'b0;
    B_data_array_wr_en = 1'b0;
    data_addr          = '0;
    data_din           = '0;
    done_vld           = 1'b0;
    done_err           = 1'b0;
    done_index         = '0;
    done_way           = 1'b0;
    case (r_state)
      S_IDLE: req_rdy = ~flush_req;
      S_FLUSH: begin
        tagram_en        = 1'b1;
        tag_arrayA_wr_en = 1'b1;
        tag_arrayB_wr_en = 1'b1;
        tag_addr         = r_cnt;
        flush_done       = &r_cnt;
      end
      S_INV: begin
        // Victim goes invalid before any data lands, so an abort at any
        // later point never exposes a valid tag over a partial line.
        tagram_en        = 1'b1;
        tag_arrayA_wr_en = ~r_way;
        tag_arrayB_wr_en = r_way;
        tag_addr         = r_index;
      end
      S_MREQ: begin
        mem_req_vld  = 1'b1;
        mem_req_addr = {r_tag, r_index};
      end
      S_FILL: begin
        mem_rsp_rdy = 1'b1;
        if (w_beat_wr) begin
          dataram_en         = 1'b1;
          A_data_array_wr_en = ~r_way;
          B_data_array_wr_en = r_way;
          data_addr          = {r_index, r_beat[0]};
          data_din           = mem_rsp_data;
        end
      end
      S_TAGWR: begin
        tagram_en        = 1'b1;
        tag_arrayA_wr_en = ~r_way;
        tag_arrayB_wr_en = r_way;
        tag_addr         = r_index;
        tag_din          = {~r_err, r_tag};
        done_vld         = 1'b1;
        done_err         = r_err;
        done_index       = r_index;
        done_way         = r_way;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 20;
  localparam int LINE_W  = 256;
  localparam int BW      = LINE_W/2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     req_vld, req_rdy, req_way;
  logic [INDEX_W-1:0]       req_index;
  logic [TAG_W-1:0]         req_tag;
  logic                     flush_req, flush_done;
  logic                     mem_req_vld, mem_req_rdy;
  logic [TAG_W+INDEX_W-1:0] mem_req_addr;
  logic                     mem_rsp_vld, mem_rsp_rdy, mem_rsp_last, mem_rsp_err;
  logic [BW-1:0]            mem_rsp_data;
  logic                     tagram_en, tag_arrayA_wr_en, tag_arrayB_wr_en;
  logic [INDEX_W-1:0]       tag_addr;
  logic [TAG_W:0]           tag_din;
  logic                     dataram_en, A_data_array_wr_en, B_data_array_wr_en;
  logic [INDEX_W:0]         data_addr;
  logic [BW-1:0]            data_din;
  logic                     done_vld, done_err, done_way;
  logic [INDEX_W-1:0]       done_index;

  icache_refill #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_index(req_index),
    .req_tag(req_tag), .req_way(req_way),
    .flush_req(flush_req), .flush_done(flush_done),
    .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_last(mem_rsp_last), .mem_rsp_err(mem_rsp_err),
    .tagram_en(tagram_en), .tag_arrayA_wr_en(tag_arrayA_wr_en),
    .tag_arrayB_wr_en(tag_arrayB_wr_en), .tag_addr(tag_addr), .tag_din(tag_din),
    .dataram_en(dataram_en), .A_data_array_wr_en(A_data_array_wr_en),
    .B_data_array_wr_en(B_data_array_wr_en), .data_addr(data_addr), .data_din(data_din),
    .done_vld(done_vld), .done_err(done_err), .done_index(done_index), .done_way(done_way)
  );

  always #5 clk = ~clk;

  // Tag RAM model fed by the DUT's write port; starts all-valid so that
  // invalidations are visible.
  logic [TAG_W:0] tagA [2**INDEX_W];
  logic [TAG_W:0] tagB [2**INDEX_W];
  logic           a_seen;
  initial for (int i = 0; i < 2**INDEX_W; i++) begin tagA[i] = '1; tagB[i] = '1; end
  always @(posedge clk) begin
    if (tagram_en && tag_arrayA_wr_en) tagA[tag_addr] <= tag_din;
    if (tagram_en && tag_arrayB_wr_en) tagB[tag_addr] <= tag_din;
    if (tag_arrayA_wr_en || A_data_array_wr_en) a_seen <= 1'b1;
  end

  // Everything except req_rdy, for the all-zero checks.
  wire [511:0] w_outs = {flush_done, mem_req_vld, mem_req_addr, mem_rsp_rdy,
                         tagram_en, tag_arrayA_wr_en, tag_arrayB_wr_en, tag_addr, tag_din,
                         dataram_en, A_data_array_wr_en, B_data_array_wr_en, data_addr,
                         data_din, done_vld, done_err, done_index, done_way};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [BW-1:0] d, input logic last, input logic err);
    mem_rsp_vld = 1'b1; mem_rsp_data = d; mem_rsp_last = last; mem_rsp_err = err; #1;
  endtask

  task automatic beat_off();
    mem_rsp_vld = 1'b0; mem_rsp_last = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = '0;
  endtask

  // Request accepted, INV, and a MREQ granted at once: leaves the DUT in FILL.
  task automatic to_fill(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tg, input logic w);
    req_vld = 1'b1; req_index = idx; req_tag = tg; req_way = w;
    tick();
    req_vld = 1'b0;
    tick();
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
  endtask

  logic [BW-1:0] d0, d1, d2;
  logic [TAG_W+INDEX_W-1:0] addr0;

  initial begin
    d0 = {4{32'hD0D0_0000}} | 128'h1;
    d1 = {4{32'hD1D1_1111}};
    d2 = {4{32'hCAFE_F00D}};
    rst_n = 1'b0; req_vld = 1'b0; req_index = '0; req_tag = '0; req_way = 1'b0;
    flush_req = 1'b0; mem_req_rdy = 1'b0; a_seen = 1'b0;
    beat_off();
    #1;
    chk("reset_outs", w_outs, '0);
    chk("reset_rdy", req_rdy, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    a_seen = 1'b0;

    // ---- basic refill, index 5, tag 0x12345, way B ----
    req_vld = 1'b1; req_index = 6'd5; req_tag = 20'h12345; req_way = 1'b1; #1;
    chk("t0_rdy", req_rdy, 1'b1);
    tick();
    req_vld = 1'b0; #1;
    chk("inv_en", {tagram_en, tag_arrayA_wr_en, tag_arrayB_wr_en}, 3'b101);
    chk("inv_addr", tag_addr, 6'd5);
    chk("inv_din", tag_din, '0);
    tick();
    mem_req_rdy = 1'b1; #1;
    chk("mreq_vld", mem_req_vld, 1'b1);
    chk("mreq_addr", mem_req_addr, {20'h12345, 6'd5});
    chk("mreq_no_en", {tagram_en, dataram_en}, 2'b00);
    tick();
    mem_req_rdy = 1'b0;
    beat(d0, 1'b0, 1'b0);
    chk("b0_en", {mem_rsp_rdy, dataram_en, A_data_array_wr_en, B_data_array_wr_en}, 4'b1101);
    chk("b0_addr", data_addr, 7'd10);
    chk("b0_din", data_din, d0);
    tick();
    beat(d1, 1'b1, 1'b0);
    chk("b1_en", {dataram_en, B_data_array_wr_en}, 2'b11);
    chk("b1_addr", data_addr, 7'd11);
    chk("b1_din", data_din, d1);
    tick();
    beat_off(); #1;
    chk("tagwr_en", {tagram_en, tag_arrayA_wr_en, tag_arrayB_wr_en}, 3'b101);
    chk("tagwr_din", tag_din, {1'b1, 20'h12345});
    chk("done", {done_vld, done_err, done_index, done_way}, {1'b1, 1'b0, 6'd5, 1'b1});
    tick();
    chk("idle_after", {done_vld, req_rdy}, 2'b01);
    chk("wayA_untouched", a_seen, 1'b0);
    chk("tagB5_model", tagB[5], {1'b1, 20'h12345});

    // ---- mem_req_rdy stalled for 4 cycles ----
    req_vld = 1'b1; req_index = 6'd3; req_tag = 20'hABCDE; req_way = 1'b0;
    tick();
    req_vld = 1'b0;
    tick();
    addr0 = {20'hABCDE, 6'd3};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_vld%0d", i), mem_req_vld, 1'b1);
      chk($sformatf("stall_addr%0d", i), mem_req_addr, addr0);
      tick();
    end
    mem_req_rdy = 1'b1; #1;
    chk("stall_grant_addr", mem_req_addr, addr0);
    tick();
    mem_req_rdy = 1'b0;
    beat(d0, 1'b0, 1'b0);
    chk("stall_b0", {A_data_array_wr_en, B_data_array_wr_en, data_addr}, {2'b10, 7'd6});
    tick();
    beat(d1, 1'b1, 1'b0);
    tick();
    beat_off(); #1;
    chk("stall_done", {done_vld, done_err, tag_arrayA_wr_en, tag_din},
        {3'b101, 1'b1, 20'hABCDE});
    tick();

    // ---- error flagged on beat 1 ----
    to_fill(6'd1, 20'hFFFFF, 1'b0);
    beat(d0, 1'b0, 1'b0);
    tick();
    beat(d1, 1'b1, 1'b1);
    chk("err_b1_still_written", dataram_en, 1'b1);
    tick();
    beat_off(); #1;
    chk("err_done", {done_vld, done_err}, 2'b11);
    chk("err_tag_din", tag_din, {1'b0, 20'hFFFFF});
    tick();

    // ---- last on beat 0 ----
    to_fill(6'd7, 20'h00001, 1'b0);
    beat(d2, 1'b1, 1'b0);
    chk("last0_wr", {A_data_array_wr_en, data_addr, data_din}, {1'b1, 7'd14, d2});
    tick();
    beat_off(); #1;
    chk("last0_done", {done_vld, done_err, tag_din}, {2'b11, 1'b0, 20'h00001});
    tick();

    // ---- three beats, last on the third ----
    to_fill(6'd2, 20'h54321, 1'b1);
    beat(d0, 1'b0, 1'b0);
    chk("three_b0", {B_data_array_wr_en, data_addr}, {1'b1, 7'd4});
    tick();
    beat(d1, 1'b0, 1'b0);
    chk("three_b1", {B_data_array_wr_en, data_addr}, {1'b1, 7'd5});
    tick();
    beat(d2, 1'b1, 1'b0);
    chk("three_b2_dropped", {mem_rsp_rdy, dataram_en, B_data_array_wr_en}, 3'b100);
    tick();
    beat_off(); #1;
    chk("three_done", {done_vld, done_err, done_index}, {2'b11, 6'd2});
    tick();

    // ---- reset during FILL after beat 0 (index 5 way B was valid) ----
    chk("pre_rst_valid", tagB[5][TAG_W], 1'b1);
    to_fill(6'd5, 20'h0BEEF, 1'b1);
    beat(d0, 1'b0, 1'b0);
    tick();
    beat_off();
    rst_n = 1'b0; #1;
    chk("rst_outs", w_outs, '0);
    chk("rst_tag_invalid", tagB[5][TAG_W], 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_no_done%0d", i), {done_vld, flush_done, req_rdy}, 3'b001);
    end

    // ---- flush and request together ----
    flush_req = 1'b1; req_vld = 1'b1; req_index = 6'd9; req_tag = 20'h77777; req_way = 1'b0; #1;
    chk("flush_rdy_low", req_rdy, 1'b0);
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("flush_en%0d", i),
          {tagram_en, tag_arrayA_wr_en, tag_arrayB_wr_en, tag_addr, tag_din, req_rdy},
          {3'b111, 6'(i), 21'd0, 1'b0});
      chk($sformatf("flush_done%0d", i), flush_done, (i == 63));
      tick();
    end
    chk("flush_back_idle", {tagram_en, flush_done, req_rdy}, 3'b001);
    chk("flush_model_A63", tagA[63], '0);
    chk("flush_model_B0", tagB[0], '0);
    tick();
    req_vld = 1'b0; #1;
    chk("post_flush_inv", {tagram_en, tag_arrayA_wr_en, tag_addr}, {2'b11, 6'd9});
    tick();
    chk("post_flush_mreq", mem_req_addr, {20'h77777, 6'd9});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
